// File: rtl/membus_bridge_if.sv
// membus_bridge_if: membus slave-port and Avalon-MM master signals of the bridge.
interface membus_bridge_if;
  logic        i_membus_rq_cyc, i_membus_rd_rq, i_membus_wr_rq, i_membus_rd_rs, i_membus_wr_rs;
  logic [17:0] i_membus_ma;
  logic [35:0] i_membus_mb_in;
  logic        o_membus_addr_ack, o_membus_rd_valid, o_timeout;
  logic [35:0] o_membus_mb_out;
  logic [17:0] o_address;
  logic        o_read, o_write;
  logic [35:0] o_writedata;
  logic [35:0] i_readdata;
  logic        i_waitrequest;
  modport slave (
    input  i_membus_rq_cyc, i_membus_rd_rq, i_membus_wr_rq, i_membus_rd_rs, i_membus_wr_rs,
           i_membus_ma, i_membus_mb_in, i_readdata, i_waitrequest,
    output o_membus_addr_ack, o_membus_rd_valid, o_timeout, o_membus_mb_out,
           o_address, o_read, o_write, o_writedata
  );
  modport master (
    output i_membus_rq_cyc, i_membus_rd_rq, i_membus_wr_rq, i_membus_rd_rs, i_membus_wr_rs,
           i_membus_ma, i_membus_mb_in, i_readdata, i_waitrequest,
    input  o_membus_addr_ack, o_membus_rd_valid, o_timeout, o_membus_mb_out,
           o_address, o_read, o_write, o_writedata
  );
endinterface

// File: rtl/membus_bridge.sv
// membus_bridge: answers membus cycles for one memory select by issuing single Avalon-MM reads/writes.
module membus_bridge #(
  parameter logic [1:0] MEM_SEL    = 2'b00,
  parameter int         RS_TIMEOUT = 255
) (
  input logic            i_clk,
  input logic            i_reset,
  membus_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, RDHOLD, WAITWR, WR} state_e;
  state_e      state_q, state_d;
  logic        armed_q, armed_d, wr_q, wr_d, abort_q, abort_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [35:0] wdata_q, wdata_d, mbout_q, mbout_d;
  logic        read_q, read_d, write_q, write_d, rdvalid_q, rdvalid_d, ack_q, ack_d, to_q, to_d;
  logic        rq, accept, waiting, expired, dropped, rd_done;
  assign rq      = bus.i_membus_rq_cyc;
  assign accept  = state_q == IDLE && rq && bus.i_membus_ma[17:16] == MEM_SEL &&
                   (bus.i_membus_rd_rq || bus.i_membus_wr_rq) && armed_q;
  assign waiting = state_q == RDHOLD || state_q == WAITWR;
  assign expired = waiting && cnt_q == 8'(RS_TIMEOUT - 1);
  // a processor that drops rq_cyc mid-read still gets the Avalon read finished, but silently
  assign dropped = abort_q || !rq;
  assign rd_done = state_q == RD && !bus.i_waitrequest && !dropped;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      armed_q   <= 1'b1;
      wr_q      <= 1'b0;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mbout_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      rdvalid_q <= 1'b0;
      ack_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      wr_q      <= wr_d;
      abort_q   <= abort_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mbout_q   <= mbout_d;
      read_q    <= read_d;
      write_q   <= write_d;
      rdvalid_q <= rdvalid_d;
      ack_q     <= ack_d;
      to_q      <= to_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (bus.i_membus_rd_rq ? RD : WAITWR) : IDLE;
      RD:      state_d = bus.i_waitrequest ? RD : dropped ? IDLE : wr_q ? WAITWR : RDHOLD;
      RDHOLD:  state_d = (!rq || bus.i_membus_rd_rs || expired) ? IDLE : RDHOLD;
      WAITWR:  state_d = !rq ? IDLE : bus.i_membus_wr_rs ? WR :
                         (bus.i_membus_rd_rs || expired) ? IDLE : WAITWR;
      WR:      state_d = bus.i_waitrequest ? WR : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    armed_d   = !rq || (armed_q && !accept);
    wr_d      = accept ? bus.i_membus_wr_rq : wr_q;
    abort_d   = state_d == RD && ((state_q == RD && abort_q) || !rq);
    cnt_d     = state_d != state_q ? '0 : waiting ? cnt_q + 8'd1 : cnt_q;
    addr_d    = accept ? bus.i_membus_ma : addr_q;
    wdata_d   = state_q == WAITWR && state_d == WR ? bus.i_membus_mb_in : wdata_q;
    mbout_d   = rd_done ? bus.i_readdata : mbout_q;
    read_d    = state_d == RD;
    write_d   = state_d == WR;
    rdvalid_d = rd_done || ((state_d == RDHOLD || state_d == WAITWR) && rdvalid_q);
    ack_d     = rd_done || (accept && !bus.i_membus_rd_rq);
    to_d      = expired && state_d == IDLE && rq && !bus.i_membus_rd_rs;
  end
  assign bus.o_membus_addr_ack = ack_q;
  assign bus.o_membus_rd_valid = rdvalid_q;
  assign bus.o_membus_mb_out   = mbout_q;
  assign bus.o_timeout         = to_q;
  assign bus.o_address         = addr_q;
  assign bus.o_read            = read_q;
  assign bus.o_write           = write_q;
  assign bus.o_writedata       = wdata_q;
endmodule

// File: tb/tb_membus_bridge.sv
// tb_membus_bridge: directed checks of the membus-to-Avalon bridge with a 4-cycle restart timeout.
module tb_membus_bridge;
  logic clk, rst;
  int total = 0, bad = 0;
  int rd_cnt = 0, wr_cnt = 0, ack_cnt = 0, to_cnt = 0, both_cnt = 0;
  logic [17:0] w_addr = '0;
  logic [35:0] w_data = '0;
  membus_bridge_if bus();
  membus_bridge #(.MEM_SEL(2'b00), .RS_TIMEOUT(4)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Avalon slave side bookkeeping: transfers complete on edges where waitrequest is low
  always @(posedge clk) begin
    if (bus.o_read && !bus.i_waitrequest) rd_cnt <= rd_cnt + 1;
    if (bus.o_write && !bus.i_waitrequest) begin
      wr_cnt <= wr_cnt + 1;
      w_addr <= bus.o_address;
      w_data <= bus.o_writedata;
    end
    if (bus.o_read && bus.o_write) both_cnt <= both_cnt + 1;
    if (bus.o_membus_addr_ack) ack_cnt <= ack_cnt + 1;
    if (bus.o_timeout) to_cnt <= to_cnt + 1;
  end
  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.i_membus_rq_cyc = 0; bus.i_membus_rd_rq = 0; bus.i_membus_wr_rq = 0;
    bus.i_membus_rd_rs = 0; bus.i_membus_wr_rs = 0; bus.i_membus_ma = '0;
    bus.i_membus_mb_in = '0; bus.i_readdata = '0; bus.i_waitrequest = 1'b1;
    step(); step();
    chk("rst_read", bus.o_read, 0);
    chk("rst_write", bus.o_write, 0);
    chk("rst_ack", bus.o_membus_addr_ack, 0);
    chk("rst_valid", bus.o_membus_rd_valid, 0);
    chk("rst_mbout", bus.o_membus_mb_out, 0);
    chk("rst_wdata", bus.o_writedata, 0);
    chk("rst_addr", bus.o_address, 0);
    chk("rst_to", bus.o_timeout, 0);
    rst = 1'b0;
    step();
    // read-only with one wait state
    bus.i_membus_rq_cyc = 1; bus.i_membus_rd_rq = 1; bus.i_membus_ma = 18'o001234;
    step();
    chk("r_read", bus.o_read, 1);
    chk("r_addr", bus.o_address, 18'o001234);
    chk("r_noack", bus.o_membus_addr_ack, 0);
    step();
    chk("r_hold", bus.o_read, 1);
    bus.i_waitrequest = 0; bus.i_readdata = 36'o123456701234;
    step();
    chk("r_done", bus.o_read, 0);
    chk("r_ack", bus.o_membus_addr_ack, 1);
    chk("r_valid", bus.o_membus_rd_valid, 1);
    chk("r_data", bus.o_membus_mb_out, 36'o123456701234);
    bus.i_waitrequest = 1; bus.i_readdata = '0;
    step();
    chk("r_ack_pulse", bus.o_membus_addr_ack, 0);
    chk("r_valid_hold", bus.o_membus_rd_valid, 1);
    bus.i_membus_rd_rs = 1;
    step();
    chk("r_valid_clr", bus.o_membus_rd_valid, 0);
    chk("r_rdcnt", rd_cnt, 1);
    chk("r_ackcnt", ack_cnt, 1);
    bus.i_membus_rd_rs = 0; bus.i_membus_rq_cyc = 0; bus.i_membus_rd_rq = 0;
    step();
    // read-modify-write, with rd_rs and wr_rs together
    bus.i_membus_rq_cyc = 1; bus.i_membus_rd_rq = 1; bus.i_membus_wr_rq = 1;
    bus.i_membus_ma = 18'o000100; bus.i_waitrequest = 0; bus.i_readdata = 36'o555;
    step();
    chk("m_read", bus.o_read, 1);
    step();
    chk("m_read_done", bus.o_read, 0);
    chk("m_valid", bus.o_membus_rd_valid, 1);
    chk("m_data", bus.o_membus_mb_out, 36'o555);
    bus.i_membus_wr_rs = 1; bus.i_membus_rd_rs = 1;
    bus.i_membus_mb_in = 36'o777777000000; bus.i_waitrequest = 1;
    step();
    chk("m_write", bus.o_write, 1);
    chk("m_wdata", bus.o_writedata, 36'o777777000000);
    chk("m_waddr", bus.o_address, 18'o000100);
    chk("m_valid_clr", bus.o_membus_rd_valid, 0);
    bus.i_membus_wr_rs = 0; bus.i_membus_rd_rs = 0; bus.i_membus_mb_in = '0;
    step();
    chk("m_write_hold", bus.o_write, 1);
    chk("m_wdata_stable", bus.o_writedata, 36'o777777000000);
    bus.i_waitrequest = 0;
    step();
    chk("m_write_done", bus.o_write, 0);
    chk("m_wrcnt", wr_cnt, 1);
    chk("m_wr_addr", w_addr, 18'o000100);
    chk("m_wr_data", w_data, 36'o777777000000);
    chk("m_rdcnt", rd_cnt, 2);
    bus.i_membus_rq_cyc = 0; bus.i_membus_rd_rq = 0; bus.i_membus_wr_rq = 0;
    step();
    // write-only
    bus.i_membus_rq_cyc = 1; bus.i_membus_wr_rq = 1; bus.i_membus_ma = 18'o000007;
    step();
    chk("w_ack", bus.o_membus_addr_ack, 1);
    chk("w_noread", bus.o_read, 0);
    bus.i_membus_wr_rs = 1; bus.i_membus_mb_in = 36'o1;
    step();
    chk("w_ack_pulse", bus.o_membus_addr_ack, 0);
    chk("w_write", bus.o_write, 1);
    chk("w_wdata", bus.o_writedata, 36'o1);
    chk("w_addr", bus.o_address, 18'o000007);
    bus.i_membus_wr_rs = 0; bus.i_membus_mb_in = '0;
    step();
    chk("w_done", bus.o_write, 0);
    chk("w_wrcnt", wr_cnt, 2);
    chk("w_wr_data", w_data, 36'o1);
    chk("w_rdcnt", rd_cnt, 2);
    bus.i_membus_rq_cyc = 0; bus.i_membus_wr_rq = 0;
    step();
    // restart timeout after read; rq_cyc stays high afterwards
    bus.i_membus_rq_cyc = 1; bus.i_membus_rd_rq = 1; bus.i_membus_ma = 18'o000010;
    bus.i_readdata = 36'o42;
    step();
    step();
    chk("t_valid", bus.o_membus_rd_valid, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t_early", bus.o_timeout, 0);
    end
    step();
    chk("t_pulse", bus.o_timeout, 1);
    chk("t_valid_clr", bus.o_membus_rd_valid, 0);
    step();
    chk("t_pulse_end", bus.o_timeout, 0);
    chk("t_noreaccept", bus.o_read, 0);
    step();
    chk("t_noreaccept2", bus.o_read, 0);
    chk("t_tocnt", to_cnt, 1);
    chk("t_wrcnt", wr_cnt, 2);
    bus.i_membus_rq_cyc = 0;
    step();
    // unselected address, then a selected one under the same rq_cyc
    bus.i_membus_rq_cyc = 1; bus.i_membus_ma = 18'o200000;
    step(); step();
    chk("d_noread", bus.o_read, 0);
    chk("d_noack", bus.o_membus_addr_ack, 0);
    bus.i_membus_ma = 18'o000020; bus.i_readdata = 36'o1;
    step();
    chk("d_read", bus.o_read, 1);
    chk("d_addr", bus.o_address, 18'o000020);
    step();
    chk("d_valid", bus.o_membus_rd_valid, 1);
    bus.i_membus_rq_cyc = 0; bus.i_membus_rd_rq = 0;
    step();
    chk("d_drop_valid", bus.o_membus_rd_valid, 0);
    chk("d_drop_noto", bus.o_timeout, 0);
    chk("d_rdcnt", rd_cnt, 4);
    // reset during a stalled write
    bus.i_membus_rq_cyc = 1; bus.i_membus_wr_rq = 1; bus.i_membus_ma = 18'o000030;
    bus.i_waitrequest = 1;
    step();
    bus.i_membus_wr_rs = 1; bus.i_membus_mb_in = 36'o123;
    step();
    chk("x_write", bus.o_write, 1);
    bus.i_membus_wr_rs = 0;
    rst = 1'b1;
    #1;
    chk("x_write_drop", bus.o_write, 0);
    chk("x_wdata_clr", bus.o_writedata, 0);
    chk("x_addr_clr", bus.o_address, 0);
    bus.i_membus_rq_cyc = 0; bus.i_membus_wr_rq = 0; bus.i_membus_mb_in = '0;
    step();
    rst = 1'b0;
    bus.i_waitrequest = 0;
    step();
    chk("x_no_write", bus.o_write, 0);
    chk("x_wrcnt", wr_cnt, 2);
    bus.i_membus_rq_cyc = 1; bus.i_membus_wr_rq = 1; bus.i_membus_ma = 18'o000040;
    step();
    chk("x_ack", bus.o_membus_addr_ack, 1);
    bus.i_membus_wr_rs = 1; bus.i_membus_mb_in = 36'o4;
    step();
    chk("x_write2", bus.o_write, 1);
    bus.i_membus_wr_rs = 0;
    step();
    chk("x_write2_done", bus.o_write, 0);
    chk("x_wrcnt2", wr_cnt, 3);
    chk("x_wr_addr", w_addr, 18'o000040);
    chk("x_wr_data", w_data, 36'o4);
    bus.i_membus_rq_cyc = 0; bus.i_membus_wr_rq = 0;
    step();
    chk("no_rw_overlap", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
